// File: rtl/inst_prefetch_queue_if.sv
// Fetch-stage bundle: redirect input, instruction ROM port and decode handshake.
// The prefetch queue uses the master view; the surrounding core and ROM use the slave view.
interface inst_prefetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          redir_valid;
    logic [31:0]   redir_pc;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_ready;
    logic [CW-1:0] q_count;

    modport master (
        input  redir_valid, redir_pc, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst, inst_pc, q_count
    );

    modport slave (
        output redir_valid, redir_pc, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, q_count
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetch with a single outstanding ROM read and a small PC-tagged queue.
// A redirect flushes queued and in-flight fetches and reloads the fetch pointer.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                   CLK,
    input logic                   RSTn,
    inst_prefetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fpc;
    logic [31:0]   addr_q;
    logic          inflight;
    logic          rstn_q;
    logic          req_c;
    logic          push_c;
    logic          pop_c;

    // Issue only while queued plus outstanding entries leave room for the response.
    always_comb begin
        req_c  = rstn_q & ~bus.redir_valid &
                 ((CW+1)'(count) + (CW+1)'(inflight) < (CW+1)'(DEPTH));
        push_c = inflight & ~bus.redir_valid;
        pop_c  = (count != '0) & bus.inst_ready;
    end

    assign bus.imem_req   = req_c;
    assign bus.imem_addr  = fpc & 32'hFFFF_FFFC;
    assign bus.inst_valid = (count != '0);
    assign bus.inst       = (count != '0) ? mem[rd_ptr].data : '0;
    assign bus.inst_pc    = (count != '0) ? mem[rd_ptr].pc   : '0;
    assign bus.q_count    = count;

    always_ff @(posedge CLK) begin
        rstn_q <= RSTn;
        if (!RSTn) begin
            fpc      <= RESET_PC;
            addr_q   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= req_c;
            if (req_c) begin
                addr_q <= bus.imem_addr;
                fpc    <= bus.imem_addr + 32'd4;
            end
            // Redirect wins: flush queue, drop the response, reload the pointer.
            if (bus.redir_valid) begin
                fpc    <= bus.redir_pc & 32'hFFFF_FFFC;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + AW'(1);
                if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push_c) - CW'(pop_c);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTn && push_c) begin
            mem[wr_ptr] <= '{pc: addr_q, data: bus.imem_rdata};
        end
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed per-cycle vector table, then random traffic
// checked against a queue-of-PCs reference model.
module tb_inst_prefetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic CLK = 1'b0;
    logic RSTn;

    inst_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic        last_req  = 1'b0;
    logic [31:0] last_addr = 32'h0;

    typedef struct {
        logic        rstn;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        int          chk;    // 0 skip, 1 normal, 2 also require zero inst/inst_pc
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        int          count;
    } vec_t;

    vec_t vecs[$];

    // ROM contents: word i holds i*0x11.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {2'b00, a[31:2]} * 32'h11;
    endfunction

    function automatic vec_t mk(input logic rstn, input logic redir, input logic [31:0] rpc,
                                input logic ready, input int chk, input logic req,
                                input logic [31:0] addr, input logic valid,
                                input logic [31:0] pc, input int count);
        vec_t v;
        v.rstn = rstn; v.redir = redir; v.rpc = rpc; v.ready = ready; v.chk = chk;
        v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.count = count;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge; ROM answers the previous cycle's request.
    task automatic drive(input logic rstn, input logic redir, input logic [31:0] rpc,
                         input logic ready);
        @(negedge CLK);
        RSTn            = rstn;
        bus.redir_valid = redir;
        bus.redir_pc    = rpc;
        bus.inst_ready  = ready;
        bus.imem_rdata  = last_req ? rom_word(last_addr) : $urandom;
        #1;
    endtask

    task automatic end_cycle();
        last_req  = bus.imem_req;
        last_addr = bus.imem_addr;
        cyc++;
    endtask

    // Reference model state
    logic        m_rq;
    logic [31:0] m_fpc;
    logic        m_infl;
    logic [31:0] m_ipc;
    logic [31:0] mq[$];

    initial begin
        RSTn            = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 32'h0;
        bus.inst_ready  = 1'b0;
        bus.imem_rdata  = 32'h0;

        // rstn, redir, rpc, ready, chk | req, addr, valid, pc, count
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 2, 0, 32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 2, 0, 32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h4,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h8,        1, 32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'hC,        1, 32'h4,        1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h10,       1, 32'h8,        1));
        // decode stalls: queue fills to DEPTH and requests stop
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 1, 32'h14,       1, 32'hC,        1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 1, 32'h18,       1, 32'hC,        2));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h1C,       1, 32'hC,        3));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h1C,       1, 32'hC,        4));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h1C,       1, 32'hC,        4));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 0, 32'h1C,       1, 32'hC,        4));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h1C,       1, 32'h10,       3));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h20,       1, 32'h14,       2));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 1, 32'h24,       1, 32'h18,       2));
        // redirect with 3 queued and a fetch in flight
        vecs.push_back(mk(1, 1, 32'h00400020, 0, 1, 0, 32'h28,       1, 32'h18,       3));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h00400020, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h00400024, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h00400028, 1, 32'h00400020, 1));
        // redirect near the top of the address space, fetch pointer wraps
        vecs.push_back(mk(1, 1, 32'hFFFFFFF8, 1, 1, 0, 32'h0040002C, 1, 32'h00400024, 1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'hFFFFFFF8, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'hFFFFFFFC, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h0,        1, 32'hFFFFFFF8, 1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h4,        1, 32'hFFFFFFFC, 1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h8,        1, 32'h0,        1));
        // unaligned redirect target
        vecs.push_back(mk(1, 1, 32'h00400023, 1, 1, 0, 32'hC,        1, 32'h4,        1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h00400020, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h00400024, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 1, 32'h00400028, 1, 32'h00400020, 1));
        // one-cycle reset with 2 queued
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h0040002C, 1, 32'h00400020, 2));
        vecs.push_back(mk(1, 0, 32'h0,        1, 2, 0, 32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h4,        0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h8,        1, 32'h0,        1));
        // back-to-back redirects: last one wins
        vecs.push_back(mk(1, 1, 32'h00000100, 1, 1, 0, 32'hC,        1, 32'h4,        1));
        vecs.push_back(mk(1, 1, 32'h00000200, 1, 1, 0, 32'h100,      0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h200,      0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h204,      0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h208,      1, 32'h200,      1));

        foreach (vecs[i]) begin
            drive(vecs[i].rstn, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
            if (vecs[i].chk > 0) begin
                check($sformatf("vec%0d imem_req", i),   32'(bus.imem_req),   32'(vecs[i].req));
                check($sformatf("vec%0d imem_addr", i),  bus.imem_addr,       vecs[i].addr);
                check($sformatf("vec%0d inst_valid", i), 32'(bus.inst_valid), 32'(vecs[i].valid));
                check($sformatf("vec%0d q_count", i),    32'(bus.q_count),    32'(vecs[i].count));
                if (vecs[i].valid) begin
                    check($sformatf("vec%0d inst_pc", i), bus.inst_pc, vecs[i].pc);
                    check($sformatf("vec%0d inst", i),    bus.inst,    rom_word(vecs[i].pc));
                end
                if (vecs[i].chk == 2) begin
                    check($sformatf("vec%0d inst_zero", i),    bus.inst,    32'h0);
                    check($sformatf("vec%0d inst_pc_zero", i), bus.inst_pc, 32'h0);
                end
            end
            end_cycle();
        end

        // Random traffic against the reference model.
        m_rq   = 1'b0;
        m_fpc  = RESET_PC;
        m_infl = 1'b0;
        m_ipc  = 32'h0;
        mq.delete();
        for (int i = 0; i < 3000; i++) begin
            logic        rstn, redir, ready, exp_req, popped;
            logic [31:0] rpc;
            rstn  = (i < 2) ? 1'b0 : ($urandom_range(99) != 0);
            redir = ($urandom_range(15) == 0);
            case ($urandom_range(3))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                default: rpc = 32'h0040_0000 | 32'($urandom_range(255));
            endcase
            if ((i % 64) < 20) ready = ($urandom_range(3) == 0);
            else               ready = ($urandom_range(3) != 0);

            drive(rstn, redir, rpc, ready);
            exp_req = m_rq && !redir && ((mq.size() + int'(m_infl)) < int'(DEPTH));
            if (i > 0) begin
                check("rnd imem_req",   32'(bus.imem_req),   32'(exp_req));
                check("rnd imem_addr",  bus.imem_addr,       m_fpc & 32'hFFFF_FFFC);
                check("rnd inst_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
                check("rnd q_count",    32'(bus.q_count),    32'(mq.size()));
                if (mq.size() != 0) begin
                    check("rnd inst_pc", bus.inst_pc, mq[0]);
                    check("rnd inst",    bus.inst,    rom_word(mq[0]));
                end
            end
            end_cycle();

            popped = (mq.size() != 0) && ready;
            if (!rstn) begin
                m_fpc  = RESET_PC;
                m_infl = 1'b0;
                mq.delete();
            end else if (redir) begin
                m_fpc  = rpc & 32'hFFFF_FFFC;
                m_infl = 1'b0;
                mq.delete();
            end else begin
                if (popped) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_ipc);
                m_infl = exp_req;
                if (exp_req) begin
                    m_ipc = m_fpc & 32'hFFFF_FFFC;
                    m_fpc = m_ipc + 32'd4;
                end
            end
            m_rq = rstn;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
